// File: rtl/ap_frame_sequencer.sv
// ---------------------------------------------------------------------------
// ap_frame_sequencer
//
// Frame scheduler for the audio-processing path. It converts the free-running
// offset-binary ADC stream to 16-bit signed samples and writes them into a
// circular sample RAM. It launches the feature engine on overlapping frames
// (FRAME_LEN long, HOP_LEN apart) and publishes a one-cycle valid strobe when
// the feature vector is complete.
//
// Optional feature: define AP_PREEMPH_EN to apply first-order pre-emphasis
//   y = sat16(x[n] - x[n-1] + (x[n-1] >>> 5)) after conversion. The filter adds
//   no latency. Without the macro the converted sample is written unchanged.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   capture enable
//   adc_data   in   offset-binary ADC sample (DATA_WIDTH)
//   buf_we     out  sample RAM write strobe
//   buf_addr   out  sample RAM write address (ADDR_W)
//   buf_wdata  out  converted signed 16-bit sample
//   fe_start   out  one-cycle frame start pulse to the feature engine
//   fe_base    out  RAM address of the first sample of the started frame
//   fe_busy    in   feature engine busy, sampled only at a frame trigger
//   fe_done    in   one-cycle pulse, feature vector complete
//   vec_valid  out  one-cycle pulse, feature vector valid
//   frame_cnt  out  published frame count, wraps modulo 2^16
//   overrun    out  sticky flag, a frame trigger was dropped
// ---------------------------------------------------------------------------
module ap_frame_sequencer #(
    parameter int DATA_WIDTH = 12,
    parameter int DECIM      = 1,
    parameter int FRAME_LEN  = 256,
    parameter int HOP_LEN    = 128,
    parameter int BUF_DEPTH  = 512
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic        [DATA_WIDTH-1:0]      adc_data,
    output logic                              buf_we,
    output logic        [$clog2(BUF_DEPTH)-1:0] buf_addr,
    output logic signed [15:0]                buf_wdata,
    output logic                              fe_start,
    output logic        [$clog2(BUF_DEPTH)-1:0] fe_base,
    input  logic                              fe_busy,
    input  logic                              fe_done,
    output logic                              vec_valid,
    output logic        [15:0]                frame_cnt,
    output logic                              overrun
);

    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam int DIV_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SCNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DECIM - 1);
    localparam logic [SCNT_W-1:0] FRAME_LAST = SCNT_W'(FRAME_LEN - 1);
    localparam logic [SCNT_W-1:0] HOP_LAST   = SCNT_W'(HOP_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_BACK  = ADDR_W'(FRAME_LEN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;

    // ------------------------------------------------------------------
    // Sample strobe divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             strobe;

    assign strobe = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (!en || strobe) div_d = '0;
        else               div_d = div_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Conversion: offset binary -> two's complement is an MSB flip, then
    // left-justify into 16 bits.
    // ------------------------------------------------------------------
    logic signed [15:0] conv_x;
    logic signed [15:0] samp_y;
    logic [2:0]         state_q, state_d;
    logic               leave_idle;

    assign conv_x     = {~adc_data[DATA_WIDTH-1], adc_data[DATA_WIDTH-2:0],
                         {(16-DATA_WIDTH){1'b0}}};
    assign leave_idle = (state_q == S_IDLE) && en;

`ifdef AP_PREEMPH_EN
    // History is forced to zero for the first sample of a new capture run,
    // which is the one captured on the same edge the FSM leaves IDLE.
    logic signed [15:0] xprev_q, xprev_d;
    logic signed [15:0] xprev_eff;
    logic signed [17:0] pe_sum;

    assign xprev_eff = leave_idle ? 16'sd0 : xprev_q;
    assign pe_sum    = 18'(conv_x) - 18'(xprev_eff) + 18'(xprev_eff >>> 5);

    always_comb begin
        if (pe_sum > 18'sd32767)       samp_y = 16'sh7FFF;
        else if (pe_sum < -18'sd32768) samp_y = 16'sh8000;
        else                           samp_y = pe_sum[15:0];
    end

    always_comb begin
        xprev_d = xprev_q;
        if (strobe)          xprev_d = conv_x;
        else if (leave_idle) xprev_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) xprev_q <= '0;
        else      xprev_q <= xprev_d;
    end
`else
    assign samp_y = conv_x;
`endif

    // ------------------------------------------------------------------
    // Write path: captured on the strobe edge, presented for one cycle.
    // ------------------------------------------------------------------
    logic                     buf_we_q;
    logic        [ADDR_W-1:0] buf_addr_q, wptr_q;
    logic signed [15:0]       buf_wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            wptr_q      <= '0;
        end else begin
            div_q    <= div_d;
            buf_we_q <= strobe;
            if (strobe) begin
                buf_addr_q  <= wptr_q;
                buf_wdata_q <= samp_y;
                wptr_q      <= wptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger counter and frame FSM.
    // Samples are counted as they appear on the RAM port, so a trigger is
    // raised in the cycle the triggering sample is written and the start
    // pulse lands one cycle later, after the RAM holds that sample.
    // ------------------------------------------------------------------
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              first_q, first_d;
    logic              ovr_q, ovr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              trig;

    // A write still draining after en falls is not counted: the next
    // capture run always restarts with a full fill.
    assign trig = en && buf_we_q && (state_q != S_IDLE) &&
                  (scnt_q == (first_q ? FRAME_LAST : HOP_LAST));

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        first_d = first_q;
        ovr_d   = ovr_q;
        base_d  = base_q;
        fcnt_d  = fcnt_q;

        if (state_q != S_IDLE && en && buf_we_q) begin
            scnt_d = trig ? '0 : scnt_q + 1'b1;
            if (trig) first_d = 1'b0;
        end
        if (!en) begin
            scnt_d  = '0;
            first_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_FILL;
                    scnt_d  = '0;
                    first_d = 1'b1;
                end
            end
            S_FILL: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (trig) begin
                    if (fe_busy) begin
                        ovr_d = 1'b1;
                    end else begin
                        state_d = S_START;
                        base_d  = buf_addr_q - BASE_BACK;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                if (trig) ovr_d = 1'b1;
            end
            S_WAIT: begin
                if (fe_done) begin
                    state_d = S_PUBLISH;
                    fcnt_d  = fcnt_q + 1'b1;
                end
                if (trig) ovr_d = 1'b1;
            end
            S_PUBLISH: begin
                state_d = en ? S_FILL : S_IDLE;
                if (trig) ovr_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            first_q <= 1'b0;
            ovr_q   <= 1'b0;
            base_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            first_q <= first_d;
            ovr_q   <= ovr_d;
            base_q  <= base_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign fe_start  = (state_q == S_START);
    assign fe_base   = base_q;
    assign vec_valid = (state_q == S_PUBLISH);
    assign frame_cnt = fcnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_ap_frame_sequencer.sv
// Directed bench for ap_frame_sequencer (default build, pre-emphasis off).
module tb_ap_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] adc_data;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic signed [15:0] buf_wdata;
    logic        fe_start;
    logic [8:0]  fe_base;
    logic        fe_busy;
    logic        fe_done;
    logic        vec_valid;
    logic [15:0] frame_cnt;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int n, vv;

    ap_frame_sequencer #(
        .DATA_WIDTH(12), .DECIM(1), .FRAME_LEN(256), .HOP_LEN(128), .BUF_DEPTH(512)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .adc_data(adc_data),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .fe_start(fe_start), .fe_base(fe_base), .fe_busy(fe_busy),
        .fe_done(fe_done), .vec_valid(vec_valid), .frame_cnt(frame_cnt),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // Step until fe_start is seen (bounded); report steps taken and any
    // vec_valid pulses seen on the way.
    task automatic wait_start(input int maxc, output int steps, output int vcount);
        steps = 0;
        vcount = 0;
        while (fe_start !== 1'b1 && steps < maxc) begin
            step(1);
            steps++;
            if (vec_valid === 1'b1) vcount++;
        end
    endtask

    // One full frame: start after exp_n steps, engine answers 10 cycles later.
    task automatic frame(input string tag, input int exp_n, input int exp_base,
                         input int exp_addr, input int exp_cnt);
        wait_start(400, n, vv);
        chk({tag, "_wait"}, n, exp_n);
        chk({tag, "_start"}, {31'd0, fe_start}, 1);
        chk({tag, "_vv_early"}, vv, 0);
        chk({tag, "_base"}, {23'd0, fe_base}, exp_base);
        chk({tag, "_addr"}, {23'd0, buf_addr}, exp_addr);
        step(10);
        fe_done = 1'b1;
        step(1);
        fe_done = 1'b0;
        chk({tag, "_vv"}, {31'd0, vec_valid}, 1);
        chk({tag, "_cnt"}, {16'd0, frame_cnt}, exp_cnt);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; adc_data = 12'h000; fe_busy = 1'b0; fe_done = 1'b0;

        // Reset held with enable on and ADC toggling
        for (int i = 0; i < 4; i++) begin
            adc_data = adc_data ^ 12'hFFF;
            step(1);
        end
        chk("rst_we", {31'd0, buf_we}, 0);
        chk("rst_start", {31'd0, fe_start}, 0);
        chk("rst_vv", {31'd0, vec_valid}, 0);
        chk("rst_ovr", {31'd0, overrun}, 0);
        chk("rst_cnt", {16'd0, frame_cnt}, 0);
        chk("rst_base", {23'd0, fe_base}, 0);

        // Release; conversion of the three corner codes
        rst = 1'b1; adc_data = 12'h800;
        step(1);
        adc_data = 12'hFFF;
        chk("cv0_we", {31'd0, buf_we}, 1);
        chk("cv0_addr", {23'd0, buf_addr}, 0);
        chk("cv0_data", {16'd0, buf_wdata}, 32'h0000);
        step(1);
        adc_data = 12'h000;
        chk("cv1_addr", {23'd0, buf_addr}, 1);
        chk("cv1_data", {16'd0, buf_wdata}, 32'h7FF0);
        step(1);
        adc_data = 12'h123;
        chk("cv2_addr", {23'd0, buf_addr}, 2);
        chk("cv2_data", {16'd0, buf_wdata}, 32'h8000);

        // First frame, hops and RAM wrap
        frame("f1", 254, 0,   256, 1);
        frame("f2", 117, 128, 384, 2);
        frame("f3", 117, 256, 0,   3);
        frame("f4", 117, 384, 128, 4);
        frame("f5", 117, 0,   256, 5);

        // fe_done coincident with a trigger: trigger dropped
        wait_start(400, n, vv);
        chk("co_wait", n, 117);
        chk("co_base", {23'd0, fe_base}, 128);
        step(127);
        chk("co_ovr0", {31'd0, overrun}, 0);
        fe_done = 1'b1;
        step(1);
        fe_done = 1'b0;
        chk("co_vv", {31'd0, vec_valid}, 1);
        chk("co_cnt", {16'd0, frame_cnt}, 6);
        chk("co_ovr1", {31'd0, overrun}, 1);
        wait_start(400, n, vv);
        chk("co_next_wait", n, 128);
        chk("co_next_base", {23'd0, fe_base}, 384);
        chk("co_next_cnt", {16'd0, frame_cnt}, 6);

        // Reset during WAIT
        step(3);
        rst = 1'b0;
        #1;
        chk("mr_we", {31'd0, buf_we}, 0);
        chk("mr_start", {31'd0, fe_start}, 0);
        chk("mr_ovr", {31'd0, overrun}, 0);
        chk("mr_cnt", {16'd0, frame_cnt}, 0);
        chk("mr_base", {23'd0, fe_base}, 0);
        step(2);
        rst = 1'b1; fe_done = 1'b1;
        step(1);
        fe_done = 1'b0;
        chk("mr_vv", {31'd0, vec_valid}, 0);
        chk("mr_addr", {23'd0, buf_addr}, 0);
        frame("mr_f", 256, 0, 256, 1);

        // fe_done held off past a hop: overrun, count not advanced
        wait_start(400, n, vv);
        chk("ho_wait", n, 117);
        chk("ho_base", {23'd0, fe_base}, 128);
        step(127);
        chk("ho_ovr0", {31'd0, overrun}, 0);
        step(1);
        chk("ho_ovr1", {31'd0, overrun}, 1);
        chk("ho_nostart", {31'd0, fe_start}, 0);
        chk("ho_cnt1", {16'd0, frame_cnt}, 1);
        step(71);
        fe_done = 1'b1;
        step(1);
        fe_done = 1'b0;
        chk("ho_vv", {31'd0, vec_valid}, 1);
        chk("ho_cnt2", {16'd0, frame_cnt}, 2);
        wait_start(400, n, vv);
        chk("ho_next_wait", n, 56);
        chk("ho_next_base", {23'd0, fe_base}, 384);

        // en dropped during WAIT: frame publishes, then a full refill
        step(2);
        en = 1'b0;
        step(8);
        fe_done = 1'b1;
        step(1);
        fe_done = 1'b0;
        chk("en_vv", {31'd0, vec_valid}, 1);
        chk("en_cnt", {16'd0, frame_cnt}, 3);
        chk("en_we", {31'd0, buf_we}, 0);
        step(9);
        en = 1'b1;
        frame("en_f", 257, 131, 387, 4);

        // fe_busy high at a trigger: dropped, next start one hop later
        fe_busy = 1'b1;
        step(117);
        chk("bz_nostart", {31'd0, fe_start}, 0);
        fe_busy = 1'b0;
        wait_start(400, n, vv);
        chk("bz_wait", n, 128);
        chk("bz_base", {23'd0, fe_base}, 387);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
